// File: rtl/decode_stage.sv
// Unpacks 32-bit fetch words into two 16-bit instructions, classifies
// each one and registers the decoded bundle for execute.
//
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   fetch_pc/instr/valid   fetch word, halfword start address, valid
//   fetch_stall            combinational hold request back to fetch
//   ex_stall, flush        execute back-pressure and redirect
//   dec_valid/pc/instr     issued instruction and its byte address
//   dec_class/rn/rm        class code and register fields
//   dec_imm/target         sign-extended immediate, branch target
module decode_stage #(
    parameter int          REG_WIDTH = 32,
    parameter logic [15:0] NOP_INSTR = 16'h0009
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_WIDTH-1:0] fetch_pc,
    input  logic [31:0]          fetch_instr,
    input  logic                 fetch_valid,
    output logic                 fetch_stall,
    input  logic                 ex_stall,
    input  logic                 flush,
    output logic                 dec_valid,
    output logic [REG_WIDTH-1:0] dec_pc,
    output logic [15:0]          dec_instr,
    output logic [2:0]           dec_class,
    output logic [3:0]           dec_rn,
    output logic [3:0]           dec_rm,
    output logic [REG_WIDTH-1:0] dec_imm,
    output logic [REG_WIDTH-1:0] dec_target
);

    localparam logic [2:0] CLS_ALU  = 3'd0;
    localparam logic [2:0] CLS_MOVI = 3'd1;
    localparam logic [2:0] CLS_BRA  = 3'd2;
    localparam logic [2:0] CLS_MEM  = 3'd3;
    localparam logic [2:0] CLS_NOP  = 3'd4;
    localparam logic [2:0] CLS_ILL  = 3'd5;

    typedef enum logic {
        EMPTY,
        HAVE_LO
    } state_e;

    state_e state_q;
    state_e state_d;

    logic [15:0]          buf_lo_q;
    logic [REG_WIDTH-1:0] buf_pc_q;

    logic [REG_WIDTH-1:0] word_pc;
    logic [REG_WIDTH-1:0] half_pc;
    logic                 unused_pc_bit;

    logic                 issue;
    logic                 bubble;
    logic                 load_buf;
    logic [15:0]          issue_op;
    logic [REG_WIDTH-1:0] issue_pc;

    logic [2:0]           cls_d;
    logic [REG_WIDTH-1:0] imm_d;
    logic [REG_WIDTH-1:0] target_d;

    logic is_nop;
    logic is_ill;
    logic is_movi;
    logic is_bra12;
    logic is_bra8;
    logic is_mem;

    // Bit 0 of the PC carries no meaning for halfword instructions.
    assign unused_pc_bit = fetch_pc[0];
    assign word_pc = {fetch_pc[REG_WIDTH-1:2], 2'b00};
    assign half_pc = {fetch_pc[REG_WIDTH-1:1], 1'b0};

    assign fetch_stall = ex_stall | (state_q == HAVE_LO);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority: flush > ex_stall > issue. A pending low halfword
    // always wins over the fetch port, which is stalled meanwhile.
    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        bubble   = 1'b0;
        load_buf = 1'b0;
        issue_op = NOP_INSTR;
        issue_pc = buf_pc_q + REG_WIDTH'(2);
        if (flush) begin
            state_d = EMPTY;
            bubble  = 1'b1;
        end else if (ex_stall) begin
            state_d = state_q;
        end else if (state_q == HAVE_LO) begin
            issue    = 1'b1;
            issue_op = buf_lo_q;
            state_d  = EMPTY;
        end else if (fetch_valid) begin
            issue    = 1'b1;
            issue_pc = half_pc;
            if (!fetch_pc[1]) begin
                issue_op = fetch_instr[31:16];
                load_buf = 1'b1;
                state_d  = HAVE_LO;
            end else begin
                issue_op = fetch_instr[15:0];
            end
        end else begin
            bubble = 1'b1;
        end
    end

    // The class predicates are disjoint on op[15:12], so the
    // first-match ordering collapses into a parallel decode.
    always_comb begin
        is_nop   = (issue_op == 16'h0009);
        is_ill   = (issue_op[15:4] == 12'hFFF);
        is_movi  = (issue_op[15:12] == 4'hE);
        is_bra12 = (issue_op[15:12] == 4'hA) ||
                   (issue_op[15:12] == 4'hB);
        is_bra8  = (issue_op[15:8] == 8'h89) ||
                   (issue_op[15:8] == 8'h8B);
        is_mem   = (issue_op[15:12] == 4'h2) ||
                   ((issue_op[15:12] == 4'h6) &&
                    (issue_op[3:0] <= 4'h2));
    end

    always_comb begin
        cls_d = CLS_ALU;
        imm_d = '0;
        unique case (1'b1)
            is_nop: begin
                cls_d = CLS_NOP;
            end
            is_ill: begin
                cls_d = CLS_ILL;
            end
            is_movi: begin
                cls_d = CLS_MOVI;
                imm_d = {{(REG_WIDTH-8){issue_op[7]}},
                         issue_op[7:0]};
            end
            is_bra12: begin
                cls_d = CLS_BRA;
                imm_d = {{(REG_WIDTH-13){issue_op[11]}},
                         issue_op[11:0], 1'b0};
            end
            is_bra8: begin
                cls_d = CLS_BRA;
                imm_d = {{(REG_WIDTH-9){issue_op[7]}},
                         issue_op[7:0], 1'b0};
            end
            is_mem: begin
                cls_d = CLS_MEM;
            end
            default: begin
                cls_d = CLS_ALU;
            end
        endcase
    end

    // Target arithmetic wraps naturally at the datapath width.
    always_comb begin
        target_d = '0;
        if (cls_d == CLS_BRA) begin
            target_d = issue_pc + REG_WIDTH'(4) + imm_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_lo_q <= '0;
            buf_pc_q <= '0;
        end else if (load_buf) begin
            buf_lo_q <= fetch_instr[15:0];
            buf_pc_q <= word_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dec_valid  <= 1'b0;
            dec_pc     <= '0;
            dec_instr  <= NOP_INSTR;
            dec_class  <= CLS_NOP;
            dec_rn     <= '0;
            dec_rm     <= '0;
            dec_imm    <= '0;
            dec_target <= '0;
        end else if (issue) begin
            dec_valid  <= 1'b1;
            dec_pc     <= issue_pc;
            dec_instr  <= issue_op;
            dec_class  <= cls_d;
            dec_rn     <= issue_op[11:8];
            dec_rm     <= issue_op[7:4];
            dec_imm    <= imm_d;
            dec_target <= target_d;
        end else if (bubble) begin
            dec_valid  <= 1'b0;
            dec_instr  <= NOP_INSTR;
            dec_class  <= CLS_NOP;
        end
    end

endmodule
